// File: rtl/register_writeback_pkg.sv
// ============================================================================
// Module      : register_writeback_pkg
// Description : Shared size codes, flag bit indices and GPR indices for the
//               register writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_writeback_pkg;

    localparam logic [1:0] SIZE_8  = 2'd0;
    localparam logic [1:0] SIZE_16 = 2'd1;
    localparam logic [1:0] SIZE_32 = 2'd2;

    localparam int FLAG_CF = 0;
    localparam int FLAG_PF = 1;
    localparam int FLAG_ZF = 2;
    localparam int FLAG_AF = 3;
    localparam int FLAG_SF = 4;
    localparam int FLAG_OF = 5;

    localparam logic [2:0] EAX = 3'd0;
    localparam logic [2:0] ECX = 3'd1;
    localparam logic [2:0] EDX = 3'd2;
    localparam logic [2:0] EBX = 3'd3;
    localparam logic [2:0] ESP = 3'd4;
    localparam logic [2:0] EBP = 3'd5;
    localparam logic [2:0] ESI = 3'd6;
    localparam logic [2:0] EDI = 3'd7;

    // The illegal size code is committed as a full 32-bit write.
    function automatic logic [1:0] legal_size(input logic [1:0] size);
        return (size == 2'd3) ? SIZE_32 : size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/register_writeback_fifo2.sv
// ============================================================================
// Module      : wb_fifo2
// Description : Two-entry in-order FIFO with async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && (count_q != 2'd2);
    assign w_do_pop  = pop && (count_q != 2'd0);
    assign count_d   = count_q + {1'b0, w_do_push} - {1'b0, w_do_pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/register_writeback.sv
// ============================================================================
// Module      : register_writeback
// Description : Buffers execute results and commits them in order to the
//               register file, EFLAGS and the scoreboard release port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_writeback
    import register_writeback_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int FLAGS_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [2:0]         ex_reg,
    input  logic               ex_reg_is_valid,
    input  logic [1:0]         ex_size,
    input  logic [DATA_W-1:0]  ex_data,
    input  logic               ex_flags_we,
    input  logic [FLAGS_W-1:0] ex_flags,
    input  logic               wb_enable,
    output logic               rf_we,
    output logic [2:0]         rf_reg,
    output logic [1:0]         rf_size,
    output logic [DATA_W-1:0]  rf_data,
    output logic               flags_we,
    output logic [FLAGS_W-1:0] flags,
    output logic [2:0]         wb_reg,
    output logic               wb_is_valid
);

    localparam int ENTRY_W = 3 + 1 + 2 + DATA_W + 1 + FLAGS_W;
    localparam int HOLD_W  = 3 + 2 + DATA_W + FLAGS_W;

    logic               w_push;
    logic               w_pop;
    logic               w_not_empty;
    logic [1:0]         w_count;
    logic [1:0]         w_count_next;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_head;

    logic [2:0]         w_h_reg;
    logic               w_h_rv;
    logic [1:0]         w_h_size;
    logic [DATA_W-1:0]  w_h_data;
    logic               w_h_fwe;
    logic [FLAGS_W-1:0] w_h_flags;

    logic               ready_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  w_out;

    assign w_not_empty  = (w_count != 2'd0);
    assign w_push       = ex_valid && ready_q;
    assign w_pop        = w_not_empty && wb_enable;
    assign w_count_next = w_count + {1'b0, w_push} - {1'b0, w_pop};

    assign w_din = {ex_reg, ex_reg_is_valid, legal_size(ex_size),
                    ex_data, ex_flags_we, ex_flags};

    wb_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .count (w_count),
        .head  (w_head)
    );

    assign {w_h_reg, w_h_rv, w_h_size, w_h_data, w_h_fwe, w_h_flags} = w_head;

    // Ready is registered from the next count so wb_enable never reaches it
    // combinationally, and it stays low throughout reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            ready_q <= (w_count_next != 2'd2);
            if (w_not_empty) begin
                hold_q <= {w_h_reg, w_h_size, w_h_data, w_h_flags};
            end
        end
    end

    assign w_out = w_not_empty ? {w_h_reg, w_h_size, w_h_data, w_h_flags} : hold_q;
    assign {rf_reg, rf_size, rf_data, flags} = w_out;

    assign ex_ready    = ready_q;
    assign wb_reg      = rf_reg;
    assign rf_we       = w_not_empty && w_h_rv && wb_enable;
    assign flags_we    = w_not_empty && w_h_fwe && wb_enable;
    assign wb_is_valid = rf_we;

endmodule

`default_nettype wire

// File: tb/tb_register_writeback.sv
// ============================================================================
// Module      : tb_register_writeback
// Description : Self-checking bench for register_writeback with a queue
//               model of the two-entry writeback buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_writeback;
    import register_writeback_pkg::*;

    typedef struct {
        logic [2:0]  r;
        logic        rv;
        logic [1:0]  sz;
        logic [31:0] d;
        logic        fwe;
        logic [5:0]  fl;
        logic        e_rf_we;
        logic        e_fwe;
        logic [1:0]  e_sz;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_ready;
    logic [2:0]  ex_reg;
    logic        ex_reg_is_valid;
    logic [1:0]  ex_size;
    logic [31:0] ex_data;
    logic        ex_flags_we;
    logic [5:0]  ex_flags;
    logic        wb_enable;
    logic        rf_we;
    logic [2:0]  rf_reg;
    logic [1:0]  rf_size;
    logic [31:0] rf_data;
    logic        flags_we;
    logic [5:0]  flags;
    logic [2:0]  wb_reg;
    logic        wb_is_valid;

    vec_t        sb_q[$];
    vec_t        tbl[7];
    logic [31:0] last_d;
    int          n_vec;
    int          n_err;

    register_writeback #(
        .DATA_W  (32),
        .FLAGS_W (6)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ex_valid        (ex_valid),
        .ex_ready        (ex_ready),
        .ex_reg          (ex_reg),
        .ex_reg_is_valid (ex_reg_is_valid),
        .ex_size         (ex_size),
        .ex_data         (ex_data),
        .ex_flags_we     (ex_flags_we),
        .ex_flags        (ex_flags),
        .wb_enable       (wb_enable),
        .rf_we           (rf_we),
        .rf_reg          (rf_reg),
        .rf_size         (rf_size),
        .rf_data         (rf_data),
        .flags_we        (flags_we),
        .flags           (flags),
        .wb_reg          (wb_reg),
        .wb_is_valid     (wb_is_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(input logic [2:0] r, input logic rv, input logic [1:0] sz,
                                input logic [31:0] d, input logic fwe, input logic [5:0] fl,
                                input logic [1:0] e_sz);
        vec_t v;
        v.r = r; v.rv = rv; v.sz = sz; v.d = d; v.fwe = fwe; v.fl = fl;
        v.e_rf_we = rv; v.e_fwe = fwe; v.e_sz = e_sz;
        return v;
    endfunction

    // Model: an entry accepted at an edge is the visible head from the next
    // low phase on, and leaves when wb_enable is high during its head cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
            chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
            chk("rst_flags_we", {31'd0, flags_we}, 32'd0);
            chk("rst_rf_data", rf_data, 32'd0);
        end else begin
            chk("ex_ready", {31'd0, ex_ready}, {31'd0, sb_q.size() != 2});
            if (wb_enable && sb_q.size() > 0) begin
                vec_t v;
                v = sb_q.pop_front();
                chk("rf_we", {31'd0, rf_we}, {31'd0, v.e_rf_we});
                chk("wb_is_valid", {31'd0, wb_is_valid}, {31'd0, v.e_rf_we});
                chk("wb_reg", {29'd0, wb_reg}, {29'd0, v.r});
                chk("rf_reg", {29'd0, rf_reg}, {29'd0, v.r});
                chk("rf_size", {30'd0, rf_size}, {30'd0, v.e_sz});
                chk("rf_data", rf_data, v.d);
                chk("flags_we", {31'd0, flags_we}, {31'd0, v.e_fwe});
                chk("flags", {26'd0, flags}, {26'd0, v.fl});
                last_d = v.d;
            end else begin
                chk("idle_rf_we", {31'd0, rf_we}, 32'd0);
                chk("idle_wb_is_valid", {31'd0, wb_is_valid}, 32'd0);
                chk("idle_flags_we", {31'd0, flags_we}, 32'd0);
                if (sb_q.size() == 0) chk("hold_rf_data", rf_data, last_d);
            end
        end
    end

    // Presents one result and returns 1ns after the edge that accepts it.
    task automatic send(input vec_t v);
        logic acc;
        int   cyc;
        ex_valid        = 1'b1;
        ex_reg          = v.r;
        ex_reg_is_valid = v.rv;
        ex_size         = v.sz;
        ex_data         = v.d;
        ex_flags_we     = v.fwe;
        ex_flags        = v.fl;
        cyc = 0;
        acc = 1'b0;
        while (!acc && cyc < 40) begin
            @(negedge clk);
            acc = ex_ready;
            @(posedge clk);
            cyc++;
        end
        if (acc) begin
            sb_q.push_back(v);
        end else begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got ex_ready=0 expected 1 within 40 cycles");
        end
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        last_d = 32'd0;
        reset = 1'b0;
        ex_valid = 1'b0;
        ex_reg = 3'd0;
        ex_reg_is_valid = 1'b0;
        ex_size = 2'd0;
        ex_data = 32'd0;
        ex_flags_we = 1'b0;
        ex_flags = 6'd0;
        wb_enable = 1'b0;

        tbl[0] = mk(EBX, 1'b1, 2'd2, 32'h1234_5678, 1'b0, 6'd0, SIZE_32);
        tbl[1] = mk(EAX, 1'b1, 2'd0, 32'h0000_00AB, 1'b0, 6'd0, SIZE_8);
        tbl[2] = mk(ECX, 1'b1, 2'd3, 32'hDEAD_BEEF, 1'b0, 6'd0, SIZE_32);
        tbl[3] = mk(EDX, 1'b0, 2'd2, 32'h0000_0000, 1'b1, 6'b000_100, SIZE_32);
        tbl[4] = mk(ESI, 1'b0, 2'd1, 32'h0000_5555, 1'b0, 6'd0, SIZE_16);
        tbl[5] = mk(EDI, 1'b1, 2'd1, 32'hFFFF_FFFF, 1'b1, 6'b110_001, SIZE_16);
        tbl[6] = mk(ESP, 1'b1, 2'd0, 32'h0000_0001, 1'b1, 6'b000_100, SIZE_8);

        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        wb_enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(tbl[i]);
            if (i == 3) chk("flags_only_zf", {31'd0, ex_flags[FLAG_ZF]}, 32'd1);
        end
        ex_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        wb_enable = 1'b0;
        fork
            begin
                send(mk(EAX, 1'b1, 2'd2, 32'hA000_0001, 1'b0, 6'd0, SIZE_32));
                send(mk(ECX, 1'b1, 2'd2, 32'hA000_0002, 1'b1, 6'b000_001, SIZE_32));
                send(mk(EDX, 1'b1, 2'd1, 32'hA000_0003, 1'b0, 6'd0, SIZE_16));
                ex_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 wb_enable = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        wb_enable = 1'b0;
        send(mk(EBX, 1'b1, 2'd2, 32'hB000_0001, 1'b0, 6'd0, SIZE_32));
        send(mk(EBP, 1'b1, 2'd2, 32'hB000_0002, 1'b0, 6'd0, SIZE_32));
        ex_valid = 1'b0;
        @(posedge clk);
        #1 wb_enable = 1'b1;
        #1 reset = 1'b0;
        sb_q.delete();
        last_d = 32'd0;
        #1;
        chk("async_rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("async_rst_wb_is_valid", {31'd0, wb_is_valid}, 32'd0);
        chk("async_rst_rf_data", rf_data, 32'd0);
        chk("async_rst_ex_ready", {31'd0, ex_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        send(mk(EAX, 1'b1, 2'd2, 32'hC0DE_0001, 1'b1, 6'b000_100, SIZE_32));
        ex_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
